// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use / multi-cycle stall and branch flush controller with registered outputs
module pipeline_hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int MULTI_CYCLES = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter logic [REG_W-1:0] BRANCH_REG = 3'b111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs_addr,
  input  logic [REG_W-1:0] id_rt_addr,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_write_reg,
  input  logic             multi_op,
  input  logic             branch_taken,
  input  logic             jump,
  output logic             stall_ctrl,
  output logic             flush_ctrl,
  output logic             branch_flag,
  output logic [1:0]       stall_cause,
  output logic [3:0]       remain
);
  typedef enum logic [2:0] {IDLE, LOAD_STALL, MULTI_STALL, RELEASE, FLUSH} state_t;
  state_t state, nxt_state;
  logic [3:0] nxt_cnt;
  logic flush_req, load_use;
  assign flush_req = branch_taken | jump;
  assign load_use = ex_mem_read & ((ex_write_reg == id_rs_addr) | (ex_write_reg == id_rt_addr));
  // next state and counter; flush preempts everything, remain doubles as the counter
  always_comb begin
    nxt_state = IDLE;
    nxt_cnt = '0;
    if (flush_req) begin
      nxt_state = FLUSH;
      nxt_cnt = 4'(FLUSH_CYCLES);
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (load_use) begin
            nxt_state = LOAD_STALL;
            nxt_cnt = 4'd1;
          end else if (multi_op && state == IDLE) begin
            nxt_state = MULTI_STALL;
            nxt_cnt = 4'(MULTI_CYCLES);
          end
        end
        MULTI_STALL: begin
          nxt_state = remain > 4'd1 ? MULTI_STALL : RELEASE;
          nxt_cnt = remain > 4'd1 ? remain - 4'd1 : 4'd0;
        end
        FLUSH: begin
          nxt_state = remain > 4'd1 ? FLUSH : IDLE;
          nxt_cnt = remain > 4'd1 ? remain - 4'd1 : 4'd0;
        end
        default: ;
      endcase
    end
  end
  // state register with outputs decoded from the next state so they are registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      remain <= '0;
      stall_ctrl <= 1'b0;
      flush_ctrl <= 1'b0;
      stall_cause <= 2'b00;
    end else begin
      state <= nxt_state;
      remain <= nxt_cnt;
      stall_ctrl <= nxt_state == LOAD_STALL || nxt_state == MULTI_STALL;
      flush_ctrl <= nxt_state == FLUSH;
      stall_cause <= nxt_state == FLUSH ? 2'b11 : nxt_state == MULTI_STALL ? 2'b10 :
                     nxt_state == LOAD_STALL ? 2'b01 : 2'b00;
    end
  end
  // write-back to the branch register flag, independent of the stall FSM
  always_ff @(posedge clock) begin
    if (reset) branch_flag <= 1'b0;
    else branch_flag <= wb_reg_write && wb_write_reg == BRANCH_REG;
  end
endmodule
